apb_arb_master: RTL

- Round-robin arbiter and APB master sequencer that shares one APB slave (the APB RAM) between NREQ requesters.
- Accepts one transfer request at a time, drives the APB SETUP/ACCESS phases, absorbs pready wait states and returns read data and error status to the winning requester.
- Sits between requester logic (test sequences, DMA, CPU stub) and the apb_if signal bundle.

---
 rtl/apb_arb_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_master
// Description : Round-robin arbiter plus APB master sequencer sharing one APB
//               slave between NREQ requesters. Define APB_TIMEOUT_EN to add an
//               ACCESS-phase watchdog of TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 penable,
    output logic [AW-1:0]        paddr,
    output logic                 pwrite,
    output logic [DW-1:0]        pwdata,
    input  logic [DW-1:0]        prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDW-1:0]  r_last;
    logic [IDW-1:0]  r_winner;
    logic [IDW-1:0]  w_winner;
    logic [IDW:0]    w_cand;
    logic            w_any;
    logic            w_done;
    logic            w_abort;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_write;

    // Search from r_last+1 upward; iterating from the farthest candidate down
    // lets the nearest valid requester overwrite and win.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = {1'b0, r_last} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && (w_cand == (IDW+1)'(i))) begin
                    w_any    = 1'b1;
                    w_winner = IDW'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDW'(i)) begin
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
                w_sel_write = req_write[i];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_tlast = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_tcnt;
    logic            w_tmo;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_tcnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_tcnt <= '0;
        end else if ((r_state == S_ACCESS) && !pready) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // The count reaches TIMEOUT on this edge when it currently sits one short.
    assign w_tmo = (r_tcnt == c_tlast);
`else
    logic w_tmo;
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready[i] = (w_winner == IDW'(i));
                    end
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register so reset drops them at once.
    assign psel    = (r_state != S_IDLE);
    assign penable = (r_state == S_ACCESS);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= S_IDLE;
            r_last    <= IDW'(NREQ - 1);
            r_winner  <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            rsp_valid <= 1'b0;
            if ((r_state == S_IDLE) && w_any) begin
                paddr    <= w_sel_addr;
                pwrite   <= w_sel_write;
                pwdata   <= w_sel_wdata;
                r_winner <= w_winner;
            end
            if (w_done || w_abort) begin
                rsp_valid <= 1'b1;
                rsp_id    <= r_winner;
                rsp_rdata <= (w_done && !pwrite) ? prdata : '0;
                rsp_err   <= w_abort || pslverr;
                r_last    <= r_winner;
            end
        end
    end

endmodule
`default_nettype wire
